// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package fetch_pkg;

  localparam int unsigned LINE_WORDS = 4;

  typedef logic [127:0] line_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD
  } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Cache-read and fetch-queue handshake bundle; master is the fetch controller.
interface fetch_ctrl_if;
  import fetch_pkg::*;

  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] ic_pc;
  logic        ic_rd_en;
  logic        ic_abort;
  line_t       ic_dout;
  logic        ic_dout_valid;
  logic        fq_full;
  logic        fq_wr_en;
  line_t       fq_data;
  logic [31:0] fq_pc;

  modport master (
    input  fetch_en, redirect_valid, redirect_pc, ic_dout, ic_dout_valid, fq_full,
    output ic_pc, ic_rd_en, ic_abort, fq_wr_en, fq_data, fq_pc
  );

  modport slave (
    output fetch_en, redirect_valid, redirect_pc, ic_dout, ic_dout_valid, fq_full,
    input  ic_pc, ic_rd_en, ic_abort, fq_wr_en, fq_data, fq_pc
  );

endinterface

// File: rtl/fetch_skid_reg.sv
// One-entry hold register for a fetched line and its word address.
module fetch_skid_reg
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        clear_i,
  input  line_t       data_i,
  input  logic [31:0] pc_i,
  output line_t       data_o,
  output logic [31:0] pc_o
);

  line_t       data_q;
  logic [31:0] pc_q;

  // Clear wins so a redirect always discards whatever was held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      pc_q   <= '0;
    end else if (clear_i) begin
      data_q <= '0;
      pc_q   <= '0;
    end else if (load_i) begin
      data_q <= data_i;
      pc_q   <= pc_i;
    end
  end

  assign data_o = data_q;
  assign pc_o   = pc_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: owns the fetch PC, issues cache reads and pushes lines
// into the fetch queue, parking one line in the skid register on back-pressure.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = LINE_WORDS,
  parameter int unsigned TIMEOUT  = 15
) (
  input logic          clk,
  input logic          rst_n,
  fetch_ctrl_if.master bus
);

  localparam int unsigned CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        hold_load, hold_clear;
  line_t       hold_data;
  logic [31:0] hold_pc;

  logic        rd_en, abort, wr_en;
  line_t       push_data;
  logic [31:0] push_pc;

  fetch_skid_reg u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (hold_load),
    .clear_i (hold_clear),
    .data_i  (bus.ic_dout),
    .pc_i    (pc_q),
    .data_o  (hold_data),
    .pc_o    (hold_pc)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = '0;
    hold_load  = 1'b0;
    hold_clear = 1'b0;
    rd_en      = (state_q == REQ);
    abort      = 1'b0;
    wr_en      = 1'b0;
    push_data  = '0;
    push_pc    = '0;

    if (bus.redirect_valid) begin
      hold_clear = 1'b1;
      abort      = (state_q == REQ);
      pc_d       = bus.redirect_pc;
      state_d    = bus.fetch_en ? REQ : IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.fetch_en) state_d = REQ;
        end
        REQ: begin
          if (bus.ic_dout_valid) begin
            pc_d = pc_q + 32'(PC_STEP);
            if (!bus.fq_full) begin
              wr_en     = 1'b1;
              push_data = bus.ic_dout;
              push_pc   = pc_q;
              state_d   = bus.fetch_en ? REQ : IDLE;
            end else begin
              hold_load = 1'b1;
              state_d   = HOLD;
            end
          end else if (!bus.fetch_en) begin
            state_d = IDLE;
          end else if (cnt_q == CNT_W'(TIMEOUT)) begin
            abort = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        HOLD: begin
          if (!bus.fq_full) begin
            wr_en     = 1'b1;
            push_data = hold_data;
            push_pc   = hold_pc;
            state_d   = bus.fetch_en ? REQ : IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.ic_pc    = pc_q;
  assign bus.ic_rd_en = rd_en;
  assign bus.ic_abort = abort;
  assign bus.fq_wr_en = wr_en;
  assign bus.fq_data  = push_data;
  assign bus.fq_pc    = push_pc;

endmodule
